uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter. It is the transmit-side counterpart of the team's UART receiver and shares its baud-tick input and its 8N1 framing. It accepts bytes through a valid/ready handshake into a one-entry holding register, so the next byte can be queued while the current frame shifts out. It sits between the host-side register interface and the `tx` pin.

## Interface
- No parameters. Framing is fixed at 8 data bits, LSB first, 1 start bit, 1 stop bit.
- `clk`  in  1  system clock; the block uses a single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_rate`  in  1  one-`clk`-wide pulse, one per bit period, from the shared baud generator.
- `tx_valid`  in  1  host presents a byte on `data_in`.
- `data_in`  in  8  byte to transmit.
- `tx_ready`  out  1  holding register is empty; a byte is accepted when `tx_valid && tx_ready`.
- `tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  a frame is in progress (state is not IDLE).

## Operation
- Holding register `hold`, flag `hold_full`. `tx_ready = !hold_full`, combinational from the flag.
- Accept: on a clock edge where `tx_valid && tx_ready`, `hold <= data_in` and `hold_full <= 1`. While `hold_full` is set, new input is ignored and `tx_valid` has no effect.
- Shifter: 8-bit `shift_reg`, 3-bit `bit_cnt`, registered `tx`.
- FSM states are IDLE, START_BIT, DATA_BITS and STOP_BIT, plus PARITY_BIT when the macro is defined.
  - **IDLE.** `tx=1`. On `baud_rate && hold_full`:
    - `shift_reg <= hold`, `hold_full <= 0`, `tx <= 0`, go to START_BIT.
  - **START_BIT.** On `baud_rate`:
    - `tx <= shift_reg[0]`, `shift_reg <= shift_reg >> 1`, `bit_cnt <= 0`, go to DATA_BITS.
  - **DATA_BITS.** On `baud_rate`:
    - If `bit_cnt != 7`: `tx <=` next LSB, shift, `bit_cnt++`.
    - If `bit_cnt == 7`: go to STOP_BIT with `tx <= 1` (PARITY_BIT with macro).
  - **STOP_BIT.** On `baud_rate`:
    - If `hold_full`: load the shifter from `hold`, clear `hold_full`, `tx <= 0`, go to START_BIT. Frames run back-to-back with no idle bit.
    - Otherwise: go to IDLE with `tx` held at 1.
- With no `baud_rate` pulse, state and `tx` hold their values.
- Simultaneous accept and transfer cannot occur, because acceptance requires `!hold_full`. `tx_ready` rises the cycle after `hold` is transferred to the shifter.
- `baud_rate` asserted on consecutive cycles: each pulse counts as one bit period (no filtering).
- Reset mid-frame: everything clears immediately and `tx` returns to 1. A truncated frame on the line is acceptable.

## Timing
- Reset values: `tx=1`, `tx_ready=1`, `tx_busy=0`, state IDLE, `hold_full=0`, `bit_cnt=0`, `shift_reg=0`.
- Accept-to-start latency: the start bit begins at the first `baud_rate` pulse strictly after the accept edge, plus one `clk` because `tx` is registered.
- Each bit lasts exactly one `baud_rate` period.
- Frame length is 10 periods, or 11 with parity.
- `tx_busy` rises with the start bit. It falls on the same edge the FSM re-enters IDLE.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - PARITY_BIT state is inserted between DATA_BITS and STOP_BIT.
  - `tx` carries even parity, the XOR of the 8 data bits, computed at load time into a 1-bit register.
  - Frame is 8E1, 11 periods.
- **Not defined:** no PARITY_BIT state and no parity register; the frame is 8N1.

## Structure
- Shared package `uart_pkg` holds:
  - `tx_state_t` enum, 3 bits to fit the optional PARITY_BIT state;
  - constant `UART_DATA_BITS = 8`;
  - constant `UART_IDLE_LEVEL = 1'b1`.
- One sub-module, `uart_tx_hold`: the holding register, `hold_full` and `tx_ready` logic, with a `take` input driven by the FSM. The FSM and shifter stay in `uart_tx`.

## Test plan
- **Reset:** assert `rst_n=0` mid-frame, then release → `tx=1`, `tx_ready=1`, `tx_busy=0`; next frame is correct.
- **Single byte 0xA5, `baud_rate` every 16 clk:**
  - `tx` sequence per bit period is 0,1,0,1,0,0,1,0,1,1;
  - `tx_busy` is high for exactly 160 clk;
  - `tx_ready` rises 1 clk after the start-bit load.
- **Back-to-back 0x00 then 0xFF, second byte queued during the first frame:**
  - second start bit follows the first stop bit immediately, with no idle period;
  - `tx_valid` asserted while `hold_full` is set is ignored.
- **`tx_valid` held with 0x3C, no `baud_rate` pulses for 100 clk:** `tx` stays 1, `tx_ready=0`, state IDLE; first pulse starts the frame.
- **`UART_TX_PARITY_EN` build, byte 0x07:** parity bit is 1, frame is 11 periods, stop bit is 1.
- **Scoreboard with 200 random bytes:** loop `tx` into the UART receiver → every byte is received intact and in order.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared UART framing constants and transmitter state encoding. Rev 1.0
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // 3 bits leave room for PARITY_BIT, which only the parity build reaches.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    PARITY_BIT = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_hold.sv
`default_nettype none
// uart_tx_hold: one-entry holding register in front of the UART shifter. Rev 1.0
module uart_tx_hold
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] data_in,
  input  logic                      take,
  output logic [UART_DATA_BITS-1:0] hold_data,
  output logic                      hold_full,
  output logic                      tx_ready
);

  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;

  // take is only raised while full, so it never collides with an accept.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (take) begin
      hold_full_d = 1'b0;
    end else if (tx_valid && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign hold_data = hold_q;
  assign hold_full = hold_full_q;
  assign tx_ready  = !hold_full_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// uart_tx: 8N1 UART transmitter driven by an external baud tick; UART_TX_PARITY_EN
// selects 8E1 framing. Rev 1.0
module uart_tx
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      baud_rate,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] data_in,
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      tx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      take;
  logic [UART_DATA_BITS-1:0] hold_data;
  logic                      hold_full;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  uart_tx_hold u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .data_in   (data_in),
    .take      (take),
    .hold_data (hold_data),
    .hold_full (hold_full),
    .tx_ready  (tx_ready)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    take      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (baud_rate) begin
      unique case (state_q)
        IDLE: begin
          tx_d = UART_IDLE_LEVEL;
          if (hold_full) begin
            shift_d = hold_data;
            take    = 1'b1;
            tx_d    = 1'b0;
            state_d = START_BIT;
`ifdef UART_TX_PARITY_EN
            parity_d = ^hold_data;
`endif
          end
        end
        START_BIT: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA_BITS;
        end
        DATA_BITS: begin
          if (bit_cnt_q != LAST_BIT) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY_BIT;
`else
            tx_d    = UART_IDLE_LEVEL;
            state_d = STOP_BIT;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = STOP_BIT;
        end
`endif
        STOP_BIT: begin
          // A queued byte starts its frame straight after the stop bit.
          if (hold_full) begin
            shift_d = hold_data;
            take    = 1'b1;
            tx_d    = 1'b0;
            state_d = START_BIT;
`ifdef UART_TX_PARITY_EN
            parity_d = ^hold_data;
`endif
          end else begin
            tx_d    = UART_IDLE_LEVEL;
            state_d = IDLE;
          end
        end
        default: begin
          tx_d    = UART_IDLE_LEVEL;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// tb_uart_tx: scoreboard bench for uart_tx with a line-level receiver model. Rev 1.0
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int BAUD_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_rate = 1'b0;
  logic       tx_valid;
  logic [7:0] data_in;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int   checks   = 0;
  int   failures = 0;
  logic baud_en  = 1'b0;
  logic mon_en   = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_rate (baud_rate),
    .tx_valid  (tx_valid),
    .data_in   (data_in),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Baud tick generator: one-clk pulse every BAUD_DIV clocks while enabled.
  initial begin
    int bcnt = 0;
    forever begin
      @(negedge clk);
      if (!baud_en) begin
        baud_rate = 1'b0;
        bcnt = 0;
      end else begin
        baud_rate = (bcnt == BAUD_DIV - 1);
        bcnt = (bcnt + 1) % BAUD_DIV;
      end
    end
  end

  // Receiver model: detect the start edge, sample each bit at its midpoint.
  initial begin
    logic       st, sp, par;
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        repeat (BAUD_DIV / 2) @(negedge clk);
        st = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (BAUD_DIV) @(negedge clk);
          d[k] = tx;
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (BAUD_DIV) @(negedge clk);
        par = tx;
`endif
        repeat (BAUD_DIV) @(negedge clk);
        sp = tx;
        chk("rx_start_bit", {31'd0, st}, 32'd0);
        chk("rx_stop_bit", {31'd0, sp}, 32'd1);
`ifdef UART_TX_PARITY_EN
        chk("rx_parity", {31'd0, par}, {31'd0, ^d});
`endif
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_frame", {24'd0, d}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", {24'd0, d}, {24'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int budget);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    data_in  = b;
    while (!tx_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  // Samples the line at bit midpoints over nframes frames and times tx_busy.
  task automatic frame_check(input logic [7:0] b0, input logic [7:0] b1, input int nframes);
    int          n = 0;
    int          w = 0;
    int          nb = 0;
    logic        prev_ready = 1'b0;
    logic [31:0] exp_v = '0;
    logic [31:0] act_v = '0;
    logic [7:0]  b;
    for (int f = 0; f < nframes; f++) begin
      b = (f == 0) ? b0 : b1;
      exp_v = {exp_v[30:0], 1'b0};
      for (int k = 0; k < 8; k++) exp_v = {exp_v[30:0], b[k]};
`ifdef UART_TX_PARITY_EN
      exp_v = {exp_v[30:0], ^b};
`endif
      exp_v = {exp_v[30:0], 1'b1};
    end
    while (!tx_busy && n < 4000) begin
      prev_ready = tx_ready;
      @(negedge clk);
      n++;
    end
    if (!tx_busy) begin
      chk("busy_rise_timeout", 32'd0, 32'd1);
    end else begin
      if (n > 0) chk("ready_low_before_load", {31'd0, prev_ready}, 32'd0);
      chk("ready_after_load", {31'd0, tx_ready}, 32'd1);
      while (tx_busy && w < 1000) begin
        if (w >= BAUD_DIV / 2 && ((w - BAUD_DIV / 2) % BAUD_DIV) == 0 && nb < nframes * FRAME) begin
          act_v = {act_v[30:0], tx};
          nb++;
        end
        @(negedge clk);
        w++;
      end
      chk("busy_width", w, nframes * FRAME * BAUD_DIV);
      chk("line_bits", act_v, exp_v);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    data_in  = 8'h00;
    baud_en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame; receiver model is parked.
    send(8'h55, 100);
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx", {31'd0, tx}, 32'd1);
    chk("midreset_ready", {31'd0, tx_ready}, 32'd1);
    chk("midreset_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5.
    fork
      frame_check(8'hA5, 8'h00, 1);
      send(8'hA5, 100);
    join
    drain(400);

    // Back-to-back 0x00 / 0xFF; a third offer while the holding register is full is ignored.
    fork
      frame_check(8'h00, 8'hFF, 2);
      begin
        send(8'h00, 100);
        send(8'hFF, 100);
        @(negedge clk);
        tx_valid = 1'b1;
        data_in  = 8'h77;
        repeat (40) @(negedge clk);
        chk("ready_low_while_full", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
      end
    join
    drain(600);

    // Byte held with no baud ticks: nothing leaves the line until the first tick.
    baud_en = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    data_in  = 8'h3C;
    @(posedge clk);
    exp_q.push_back(8'h3C);
    repeat (100) @(negedge clk);
    chk("nobaud_tx", {31'd0, tx}, 32'd1);
    chk("nobaud_ready", {31'd0, tx_ready}, 32'd0);
    chk("nobaud_busy", {31'd0, tx_busy}, 32'd0);
    tx_valid = 1'b0;
    fork
      frame_check(8'h3C, 8'h00, 1);
      begin
        @(negedge clk);
        baud_en = 1'b1;
      end
    join
    drain(400);

    // Random traffic through the scoreboard.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
      send(8'($urandom), 500);
    end
    drain(2000);
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
